// File: rtl/det_pkg.sv
// Shared state encoding for the 101 detector family and the windowed event counter.
package det_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  // Window-counter width; a 1-bit minimum keeps degenerate sizes legal.
  function automatic int unsigned win_bits(input int unsigned window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

endpackage

// File: rtl/det_result_slot.sv
// One-entry valid/ready result register: loads when empty or draining, flags lost results.
module det_result_slot #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_count,
  input  logic             load_sat,
  input  logic             rdy,
  output logic             vld,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             drop
);

  logic take_c;
  logic accept_c;

  assign take_c   = vld & rdy;
  assign accept_c = load & (~vld | take_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      count <= '0;
      sat   <= 1'b0;
      drop  <= 1'b0;
    end else begin
      if (accept_c) begin
        vld   <= 1'b1;
        count <= load_count;
        sat   <= load_sat;
      end else if (take_c) begin
        vld <= 1'b0;
      end
      // Sticky until reset: a completed window found the slot full.
      if (load && !accept_c) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/det_101_event_counter.sv
// Counts 101-detector match pulses over fixed windows and hands each window's total
// to a one-entry valid/ready result slot.
module det_101_event_counter
  import det_pkg::*;
#(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_det,
  input  logic             i_en,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat,
  output logic             o_drop,
  output logic [1:0]       o_state
);

  localparam int unsigned      WIN_W    = win_bits(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] win_nxt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W-1:0] acc_inc;
  logic             sat;
  logic             sat_nxt;
  logic             sat_inc;
  logic             offer_c;
  logic [CNT_W-1:0] offer_count_c;
  logic             offer_sat_c;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_IDLE;
      win   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      acc   <= acc_nxt;
      sat   <= sat_nxt;
    end
  end

  // Saturating accumulate; the flag marks a pulse that could not be counted.
  always_comb begin
    acc_inc = acc;
    sat_inc = sat;
    if (i_det) begin
      if (acc == CNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        acc_inc = acc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    win_nxt       = win;
    acc_nxt       = acc;
    sat_nxt       = sat;
    offer_c       = 1'b0;
    offer_count_c = '0;
    offer_sat_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        win_nxt = '0;
        acc_nxt = '0;
        sat_nxt = 1'b0;
        if (i_en) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_en) begin
          // Abandon the partial window; the result slot keeps any pending value.
          state_nxt = ST_IDLE;
          win_nxt   = '0;
          acc_nxt   = '0;
          sat_nxt   = 1'b0;
        end else if (win == WIN_LAST) begin
          offer_c       = 1'b1;
          offer_count_c = acc_inc;
          offer_sat_c   = sat_inc;
          win_nxt       = '0;
          acc_nxt       = '0;
          sat_nxt       = 1'b0;
        end else begin
          win_nxt = win + WIN_W'(1);
          acc_nxt = acc_inc;
          sat_nxt = sat_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        win_nxt   = '0;
        acc_nxt   = '0;
        sat_nxt   = 1'b0;
      end
    endcase
  end

  det_result_slot #(
    .CNT_W (CNT_W)
  ) u_slot (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .load       (offer_c),
    .load_count (offer_count_c),
    .load_sat   (offer_sat_c),
    .rdy        (i_rdy),
    .vld        (o_vld),
    .count      (o_count),
    .sat        (o_sat),
    .drop       (o_drop)
  );

  assign o_state = state;

endmodule

// File: tb/tb_det_101_event_counter.sv
// Scoreboard bench for det_101_event_counter: a window/event model pushes expected
// results, a separate monitor pops them whenever the DUT presents a result.
module tb_det_101_event_counter;

  localparam int unsigned WINDOW = 16;
  localparam int unsigned CNT_W  = 3;
  localparam int          MAXC   = 7;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_det = 1'b1;
  logic             i_en  = 1'b1;
  logic             i_rdy = 1'b0;
  logic             o_vld;
  logic [CNT_W-1:0] o_count;
  logic             o_sat;
  logic             o_drop;
  logic [1:0]       o_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int count;
    bit sat;
  } res_t;

  res_t exp_q[$];

  bit m_running = 1'b0;
  bit m_full    = 1'b0;
  bit m_drop    = 1'b0;
  bit m_rst     = 1'b0;
  int m_phase   = 0;
  int m_events  = 0;

  det_101_event_counter #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_det   (i_det),
    .i_en    (i_en),
    .i_rdy   (i_rdy),
    .o_vld   (o_vld),
    .o_count (o_count),
    .o_sat   (o_sat),
    .o_drop  (o_drop),
    .o_state (o_state)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit d, input bit y);
    @(posedge i_clk);
    #2;
    i_rst = r;
    i_en  = e;
    i_det = d;
    i_rdy = y;
  endtask

  task automatic wait_vld(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge i_clk);
      if (o_vld) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: o_vld=0 after %0d cycles, required 1", name, max_cycles);
    end
  endtask

  initial begin
    fork
      begin : model_p
        bit   consume;
        bit   produced;
        res_t r;
        forever begin
          @(posedge i_clk);
          if (!i_rst) begin
            m_running = 1'b0;
            m_full    = 1'b0;
            m_drop    = 1'b0;
            m_rst     = 1'b1;
            exp_q.delete();
          end else begin
            m_rst    = 1'b0;
            consume  = m_full && i_rdy;
            produced = 1'b0;
            if (!m_running) begin
              if (i_en) begin
                m_running = 1'b1;
                m_phase   = 0;
                m_events  = 0;
              end
            end else if (!i_en) begin
              m_running = 1'b0;
            end else begin
              m_events += int'(i_det);
              if (m_phase == WINDOW - 1) begin
                produced = 1'b1;
                r.count  = (m_events > MAXC) ? MAXC : m_events;
                r.sat    = (m_events > MAXC);
                m_phase  = 0;
                m_events = 0;
              end else begin
                m_phase++;
              end
            end
            if (produced && (!m_full || consume)) begin
              exp_q.push_back(r);
              m_full = 1'b1;
            end else if (produced) begin
              m_drop = 1'b1;
            end else if (consume) begin
              m_full = 1'b0;
            end
          end
        end
      end
      begin : monitor_p
        forever begin
          @(negedge i_clk);
          check("o_vld", int'(o_vld), int'(m_full));
          check("o_drop", int'(o_drop), int'(m_drop));
          check("o_state", int'(o_state), m_running ? 1 : 0);
          if (m_rst) begin
            check("rst_o_count", int'(o_count), 0);
            check("rst_o_sat", int'(o_sat), 0);
          end
          if (o_vld) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL result: o_vld=1 with o_count=%0d, required no result", o_count);
            end else begin
              check("o_count", int'(o_count), exp_q[0].count);
              check("o_sat", int'(o_sat), int'(exp_q[0].sat));
              if (i_rdy) void'(exp_q.pop_front());
            end
          end
        end
      end
    join_none

    // Reset held with enable and detect active.
    drive(0, 1, 1, 0);
    @(negedge i_clk);
    check("reset_vld", int'(o_vld), 0);
    check("reset_state", int'(o_state), 0);

    // Basic window: three pulses, consumer always ready.
    drive(1, 1, 0, 1);
    for (int k = 0; k < 16; k++) drive(1, 1, (k == 2 || k == 7 || k == 11), 1);
    wait_vld("basic_wait", 4);
    check("basic_count", int'(o_count), 3);
    check("basic_sat", int'(o_sat), 0);
    @(negedge i_clk);
    check("basic_one_cycle", int'(o_vld), 0);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);

    // Saturation, then a fresh window counting from zero.
    drive(1, 1, 1, 1);
    for (int k = 0; k < 16; k++) drive(1, 1, 1, 1);
    drive(1, 1, 0, 1);
    wait_vld("sat_wait", 4);
    check("sat_count", int'(o_count), MAXC);
    check("sat_flag", int'(o_sat), 1);
    for (int k = 1; k < 16; k++) drive(1, 1, (k == 4 || k == 9), 1);
    wait_vld("sat_next_wait", 4);
    check("sat_next_count", int'(o_count), 2);
    check("sat_next_flag", int'(o_sat), 0);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);

    // Backpressure across two window ends.
    drive(1, 1, 0, 0);
    for (int k = 0; k < 32; k++) drive(1, 1, ((k % 16) % 5 == 0), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("bp_held_vld", int'(o_vld), 1);
    check("bp_held_count", int'(o_count), 4);
    check("bp_drop", int'(o_drop), 1);
    drive(1, 0, 0, 1);
    @(posedge i_clk);
    @(negedge i_clk);
    check("bp_consumed_once", int'(o_vld), 0);
    drive(1, 0, 0, 1);

    // Disable at window cycle 5, then a fresh window.
    drive(1, 1, 0, 1);
    for (int k = 0; k < 5; k++) drive(1, 1, (k == 1 || k == 3), 1);
    drive(1, 0, 0, 1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge i_clk);
        if (o_vld) seen = 1'b1;
      end
      check("disable_no_vld", int'(seen), 0);
    end
    drive(1, 1, 0, 1);
    for (int k = 0; k < 16; k++) drive(1, 1, (k == 6), 1);
    wait_vld("reenable_wait", 4);
    check("reenable_count", int'(o_count), 1);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);

    // Reset with a held result and a half-done window.
    drive(1, 1, 0, 0);
    for (int k = 0; k < 16; k++) drive(1, 1, (k == 3 || k == 8), 0);
    for (int k = 0; k < 8; k++) drive(1, 1, (k % 2 == 1), 0);
    @(negedge i_clk);
    check("midrst_pre_vld", int'(o_vld), 1);
    drive(0, 1, 1, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("midrst_vld", int'(o_vld), 0);
    check("midrst_count", int'(o_count), 0);
    check("midrst_sat", int'(o_sat), 0);
    check("midrst_drop", int'(o_drop), 0);
    check("midrst_state", int'(o_state), 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 1);

    // Randomized traffic with varying pulse density and readiness.
    begin
      int density;
      int rdy_pct;
      density = 50;
      rdy_pct = 75;
      for (int n = 0; n < 3000; n++) begin
        if (n % 64 == 0) begin
          density = int'($urandom_range(100, 0));
          rdy_pct = int'($urandom_range(100, 0));
        end
        drive(($urandom_range(699, 0) != 0),
              ($urandom_range(99, 0) < 97),
              (int'($urandom_range(99, 0)) < density),
              (int'($urandom_range(99, 0)) < rdy_pct));
      end
    end

    for (int k = 0; k < 4; k++) drive(1, 0, 0, 1);
    @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
